// File: rtl/dart_thrower.sv
// Monte-Carlo pi dart thrower: LFSR darts land in a SIDE x SIDE square and are plotted with a
// one-cycle write strobe, while total darts and quarter-circle hits are counted.
module dart_thrower #(
  parameter int          SIDE      = 480,
  parameter int          NUM_DARTS = 100000,
  parameter int          COUNT_W   = 20,
  parameter logic [19:0] SEED      = 20'h5A5A5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [8:0]         writeX,
  output logic [8:0]         writeY,
  output logic               wrEnable,
  output logic [COUNT_W-1:0] totalCount,
  output logic [COUNT_W-1:0] insideCount,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GEN    = 3'd1,
    S_SQUARE = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [19:0]        SEED_EFF = (SEED == 20'h00000) ? 20'h00001 : SEED;
  localparam logic [8:0]         SIDE_W   = 9'(SIDE);
  localparam logic [18:0]        SIDE_SQ  = 19'(SIDE * SIDE);
  localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(NUM_DARTS - 1);
  localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  logic [19:0]        r_lfsr;
  logic [8:0]         r_x;
  logic [8:0]         r_y;
  logic [18:0]        r_dist2;
  logic               r_wr;
  logic [COUNT_W-1:0] r_total;
  logic [COUNT_W-1:0] r_inside;
  logic               r_busy;
  logic               r_done;

  logic [19:0] w_lfsr_next;
  logic [8:0]  w_cx;
  logic [8:0]  w_cy;
  logic        w_hit;
  logic [18:0] w_dist2;

  assign w_lfsr_next = {r_lfsr[18:0], r_lfsr[19] ^ r_lfsr[16]};
  assign w_cx        = r_lfsr[8:0];
  assign w_cy        = r_lfsr[17:9];
  assign w_hit       = (w_cx < SIDE_W) && (w_cy < SIDE_W);
  assign w_dist2     = (19'(r_x) * 19'(r_x)) + (19'(r_y) * 19'(r_y));

  assign writeX      = r_x;
  assign writeY      = r_y;
  assign wrEnable    = r_wr;
  assign totalCount  = r_total;
  assign insideCount = r_inside;
  assign busy        = r_busy;
  assign done        = r_done;

  // Dart FSM: generate/reject, square the distance, strobe the pixel and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_lfsr   <= SEED_EFF;
      r_x      <= 9'd0;
      r_y      <= 9'd0;
      r_dist2  <= 19'd0;
      r_wr     <= 1'b0;
      r_total  <= CNT_ZERO;
      r_inside <= CNT_ZERO;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_GEN;
            r_lfsr   <= SEED_EFF;
            r_total  <= CNT_ZERO;
            r_inside <= CNT_ZERO;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
          end else begin
            r_state <= r_state;
          end
        end
        S_GEN: begin
          r_lfsr <= w_lfsr_next;
          if (w_hit) begin
            r_x     <= w_cx;
            r_y     <= w_cy;
            r_state <= S_SQUARE;
          end else begin
            r_state <= S_GEN;
          end
        end
        S_SQUARE: begin
          r_lfsr  <= w_lfsr_next;
          r_dist2 <= w_dist2;
          r_wr    <= 1'b1;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_lfsr  <= w_lfsr_next;
          r_wr    <= 1'b0;
          r_total <= r_total + CNT_ONE;
          // Boundary darts (dist2 == SIDE^2) count as outside.
          if (r_dist2 < SIDE_SQ) begin
            r_inside <= r_inside + CNT_ONE;
          end else begin
            r_inside <= r_inside;
          end
          if (r_total == LAST_IDX) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_GEN;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_wr    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dart_thrower.sv
// Bench for dart_thrower: three instances (4 darts, 1000 darts, SIDE=8) checked every cycle
// against a dart-schedule model derived from the LFSR value stream.
module tb_dart_thrower;

  localparam int NI   = 3;
  localparam int MAXD = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b [NI];
  logic        st    [NI];
  logic [8:0]  wx    [NI];
  logic [8:0]  wy    [NI];
  logic        we    [NI];
  logic [19:0] tc    [NI];
  logic [19:0] ic    [NI];
  logic        bz    [NI];
  logic        dn    [NI];

  dart_thrower #(.SIDE(480), .NUM_DARTS(4), .COUNT_W(20), .SEED(20'h5A5A5)) u_a (
    .clk(clk), .rst_n(rst_b[0]), .start(st[0]), .writeX(wx[0]), .writeY(wy[0]),
    .wrEnable(we[0]), .totalCount(tc[0]), .insideCount(ic[0]), .busy(bz[0]), .done(dn[0]));
  dart_thrower #(.SIDE(480), .NUM_DARTS(1000), .COUNT_W(20), .SEED(20'h5A5A5)) u_b (
    .clk(clk), .rst_n(rst_b[1]), .start(st[1]), .writeX(wx[1]), .writeY(wy[1]),
    .wrEnable(we[1]), .totalCount(tc[1]), .insideCount(ic[1]), .busy(bz[1]), .done(dn[1]));
  dart_thrower #(.SIDE(8), .NUM_DARTS(3), .COUNT_W(20), .SEED(20'h5A5A5)) u_c (
    .clk(clk), .rst_n(rst_b[2]), .start(st[2]), .writeX(wx[2]), .writeY(wy[2]),
    .wrEnable(we[2]), .totalCount(tc[2]), .insideCount(ic[2]), .busy(bz[2]), .done(dn[2]));

  int checks = 0;
  int errors = 0;

  // Expected schedule: e_k = index (cycles after the start edge) of the LFSR value that was accepted.
  int e_k [NI][MAXD];
  int e_x [NI][MAXD];
  int e_y [NI][MAXD];
  int e_in_tot [NI];
  int done_idx [NI];
  int m_n [NI] = '{-1, -1, -1};
  int cnt_a = 0;
  int rec_sel = 0;
  logic [17:0] run1[$];
  logic [17:0] run2[$];

  function automatic int side_of(input int i);
    case (i)
      2:       return 8;
      default: return 480;
    endcase
  endfunction

  function automatic int num_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1000;
      default: return 3;
    endcase
  endfunction

  function automatic logic [19:0] lfsr_step(input logic [19:0] v);
    return {v[18:0], v[19] ^ v[16]};
  endfunction

  function automatic int inside_f(input int x, input int y, input int s);
    return (x * x + y * y < s * s) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input int idx, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0d expected=%0d at %0t", nm, idx, act, exp, $time);
    end
  endtask

  // One LFSR value per busy cycle; an accepted value also consumes the next two (square, write).
  task automatic build_model();
    logic [19:0] v;
    int k;
    int d;
    for (int i = 0; i < NI; i++) begin
      v = 20'h5A5A5;
      k = 0;
      d = 0;
      e_in_tot[i] = 0;
      while (d < num_of(i) && k < 4000000) begin
        if (int'(v[8:0]) < side_of(i) && int'(v[17:9]) < side_of(i)) begin
          e_k[i][d] = k;
          e_x[i][d] = int'(v[8:0]);
          e_y[i][d] = int'(v[17:9]);
          e_in_tot[i] += inside_f(e_x[i][d], e_y[i][d], side_of(i));
          d++;
          v = lfsr_step(lfsr_step(lfsr_step(v)));
          k += 3;
        end else begin
          v = lfsr_step(v);
          k++;
        end
      end
      done_idx[i] = e_k[i][num_of(i) - 1] + 3;
    end
  endtask

  // Model cycle position: -1 when idle since reset, else cycles since the honoured start.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_b[i]) m_n[i] <= -1;
      else if (st[i] && (m_n[i] < 0 || m_n[i] >= done_idx[i])) m_n[i] <= 0;
      else if (m_n[i] >= 0) m_n[i] <= m_n[i] + 1;
    end
  end

  // Per-cycle compare of every instance against the schedule.
  always @(negedge clk) begin : cmp
    int n;
    int cnt;
    int ins;
    int xd;
    int last;
    logic ewe;
    for (int i = 0; i < NI; i++) begin
      if (!rst_b[i] || m_n[i] < 0) begin
        chk("we", i, we[i], 0);
        chk("total", i, tc[i], 0);
        chk("inside", i, ic[i], 0);
        chk("busy", i, bz[i], 0);
        chk("done", i, dn[i], 0);
        chk("x_rst", i, wx[i], 0);
        chk("y_rst", i, wy[i], 0);
      end else begin
        n = m_n[i];
        cnt = 0;
        ins = 0;
        xd = 0;
        ewe = 1'b0;
        last = num_of(i) - 1;
        if (n >= done_idx[i]) begin
          cnt = num_of(i);
          ins = e_in_tot[i];
        end else begin
          for (int d = 0; d < num_of(i); d++) begin
            if (e_k[i][d] + 2 < n) begin
              cnt++;
              ins += inside_f(e_x[i][d], e_y[i][d], side_of(i));
            end else begin
              if (e_k[i][d] + 2 == n) begin
                ewe = 1'b1;
                xd = d;
              end
              break;
            end
          end
        end
        chk("we", i, we[i], ewe);
        chk("total", i, tc[i], cnt);
        chk("inside", i, ic[i], ins);
        chk("busy", i, bz[i], (n < done_idx[i]) ? 1 : 0);
        chk("done", i, dn[i], (n >= done_idx[i]) ? 1 : 0);
        if (ewe) begin
          chk("x", i, wx[i], e_x[i][xd]);
          chk("y", i, wy[i], e_y[i][xd]);
        end else if (n >= done_idx[i]) begin
          chk("x_hold", i, wx[i], e_x[i][last]);
          chk("y_hold", i, wy[i], e_y[i][last]);
        end
      end
    end
  end

  // Strobe recorder and coordinate-range checks.
  always @(negedge clk) begin
    if (we[0]) begin
      cnt_a <= cnt_a + 1;
      chk("a_x_range", 0, (wx[0] < 9'd480) ? 1 : 0, 1);
      chk("a_y_range", 0, (wy[0] < 9'd480) ? 1 : 0, 1);
    end
    if (we[2]) begin
      chk("c_x_range", 2, (wx[2] < 9'd8) ? 1 : 0, 1);
      chk("c_y_range", 2, (wy[2] < 9'd8) ? 1 : 0, 1);
    end
    if (we[1]) begin
      if (rec_sel == 1) run1.push_back({wx[1], wy[1]});
      else if (rec_sel == 2) run2.push_back({wx[1], wy[1]});
    end
  end

  task automatic pulse(input int i);
    @(negedge clk);
    st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int c;
    c = 0;
    while (!dn[i] && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("done_reached", i, dn[i], 1);
  endtask

  task automatic wait_strobe(input int i);
    int c;
    c = 0;
    @(posedge clk);
    #1;
    while (!we[i] && c < 400) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("strobe_reached", i, we[i], 1);
  endtask

  initial begin : main
    int mism;
    int lim;
    build_model();

    // Hand-computed pins of the model itself.
    chk("pin_step", 0, lfsr_step(20'h5A5A5), 20'hB4B4B);
    chk("pin_dart0_k", 1, e_k[1][0], 0);
    chk("pin_dart0_x", 1, e_x[1][0], 421);
    chk("pin_dart0_y", 1, e_y[1][0], 210);
    chk("pin_dart0_in", 1, inside_f(421, 210, 480), 1);
    chk("pin_7_7", 2, inside_f(7, 7, 8), 0);
    chk("pin_0_7", 2, inside_f(0, 7, 8), 1);
    chk("pin_edge", 1, inside_f(0, 480, 480), 0);

    for (int i = 0; i < NI; i++) begin
      rst_b[i] = 1'b0;
      st[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_we", 1, we[1], 0);
    chk("rst_total", 1, tc[1], 0);
    chk("rst_busy", 1, bz[1], 0);
    for (int i = 0; i < NI; i++) rst_b[i] = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_strobes", 0, cnt_a, 0);

    rec_sel = 1;
    repeat ($urandom_range(1, 7)) @(negedge clk);
    for (int i = 0; i < NI; i++) st[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) st[i] = 1'b0;

    wait_done(0, 400);
    chk("a_strobes", 0, cnt_a, 4);
    chk("a_total", 0, tc[0], 4);
    chk("a_busy", 0, bz[0], 0);
    repeat (50) @(negedge clk);
    chk("a_done_held", 0, dn[0], 1);
    chk("a_strobes_held", 0, cnt_a, 4);

    wait_done(1, 8000);
    chk("b_total", 1, tc[1], 1000);
    chk("b_inside", 1, ic[1], e_in_tot[1]);
    chk("b_run1_len", 1, run1.size(), 1000);

    wait_done(2, 50000);
    chk("c_total", 2, tc[2], 3);
    chk("c_inside", 2, ic[2], e_in_tot[2]);

    // Restart with start pulses landing mid-run, one of them during a write strobe.
    rec_sel = 2;
    pulse(1);
    wait_strobe(1);
    @(negedge clk);
    st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    for (int p = 0; p < 3; p++) begin
      repeat ($urandom_range(20, 600)) @(negedge clk);
      if (m_n[1] >= 0 && m_n[1] < done_idx[1] - 4) begin
        st[1] = 1'b1;
        @(negedge clk);
        st[1] = 1'b0;
      end
    end
    wait_done(1, 8000);
    chk("b_run2_total", 1, tc[1], 1000);
    chk("b_run2_len", 1, run2.size(), 1000);
    mism = 0;
    lim = (run1.size() < run2.size()) ? run1.size() : run2.size();
    for (int d = 0; d < lim; d++) if (run1[d] != run2[d]) mism++;
    chk("b_repeat_seq", 1, mism, 0);

    // Reset during a write strobe, then restart.
    rec_sel = 0;
    pulse(1);
    repeat ($urandom_range(1, 30)) wait_strobe(1);
    rst_b[1] = 1'b0;
    #1;
    chk("rst_mid_we", 1, we[1], 0);
    chk("rst_mid_total", 1, tc[1], 0);
    chk("rst_mid_inside", 1, ic[1], 0);
    chk("rst_mid_busy", 1, bz[1], 0);
    repeat (3) @(negedge clk);
    rst_b[1] = 1'b1;
    pulse(1);
    wait_strobe(1);
    chk("first_x", 1, wx[1], 421);
    chk("first_y", 1, wy[1], 210);
    chk("first_total", 1, tc[1], 0);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
